// File: rtl/mix_columns_seq.sv
// Iterative AES MixColumns engine: transforms COLS_PER_CYCLE columns of a
// 128-bit state per busy cycle, with valid/ready handshakes on both sides.
module mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [2:0] STEP = 3'(COLS_PER_CYCLE);

  state_t       state, state_next;
  logic [127:0] work, work_next;
  logic [1:0]   col_cnt, col_cnt_next;
  logic [2:0]   col_sum;
  int           idx;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // Row 0 byte sits in the MSB of the column word.
  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] r0, r1, r2, r3;
    {a0, a1, a2, a3} = col;
    r0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
    r1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
    r2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
    r3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
    return {r0, r1, r2, r3};
  endfunction

  assign col_sum   = {1'b0, col_cnt} + STEP;
  assign in_ready  = (state == IDLE);
  assign busy      = (state == BUSY);
  assign out_valid = (state == DONE);
  assign out_data  = work;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      work    <= '0;
      col_cnt <= '0;
    end else begin
      state   <= state_next;
      work    <= work_next;
      col_cnt <= col_cnt_next;
    end
  end

  always_comb begin
    state_next   = state;
    work_next    = work;
    col_cnt_next = col_cnt;
    idx          = 0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          work_next    = in_data;
          col_cnt_next = '0;
          state_next   = BUSY;
        end
      end
      BUSY: begin
        // Columns handled in one step are disjoint, so reading the old word is safe.
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
          idx = int'(col_cnt) + k;
          work_next[127-32*idx -: 32] = mix_col(work[127-32*idx -: 32]);
        end
        col_cnt_next = col_sum[1:0];
        if (col_sum == 3'd4) state_next = DONE;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
